// File: rtl/rd53_link_pkg.sv
// -----------------------------------------------------------------------------
// rd53_link_pkg
// Shared definitions for the RD53 link receive path. This package has no ports.
// It holds the two legal sync headers, the gearbox buffer and block widths, the
// aligner FSM state type, the extracted-block struct, and a header-legality
// helper function.
// -----------------------------------------------------------------------------
package rd53_link_pkg;

    localparam logic [1:0]  C_DATA_HEADER = 2'b01;
    localparam logic [1:0]  C_CMD_HEADER  = 2'b10;

    localparam int unsigned BUF_W     = 194;
    localparam int unsigned BLK_W     = 66;
    localparam int unsigned PAYLOAD_W = 64;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } align_state_t;

    typedef struct packed {
        logic [1:0]           hdr;
        logic [PAYLOAD_W-1:0] data;
    } blk_t;

    // A sync header is legal only as data (01) or command (10).
    function automatic logic hdr_is_valid(input logic [1:0] hdr);
        return (hdr == C_DATA_HEADER) || (hdr == C_CMD_HEADER);
    endfunction

endpackage

// File: rtl/descrambler_58.sv
// -----------------------------------------------------------------------------
// descrambler_58
// Self-synchronous descrambler for the polynomial 1 + x^39 + x^58. It handles
// one 64-bit payload per enabled cycle, MSB first. The 58-bit history holds
// received (scrambled) bits, so a single bit error corrupts only a few output
// bits and the descrambler recovers on its own.
// This module is built only when FRAME_ALIGNER_DESCRAMBLE_EN is defined.
// Ports:
//   clk_i, rst_ni  clock, asynchronous active-low reset (clears history)
//   clr            synchronous clear of the history (wins over en)
//   en             consume data_in and advance the history
//   data_in        scrambled payload
//   data_out       descrambled payload (combinational from data_in + history)
// -----------------------------------------------------------------------------
module descrambler_58
    import rd53_link_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 clr,
    input  logic                 en,
    input  logic [PAYLOAD_W-1:0] data_in,
    output logic [PAYLOAD_W-1:0] data_out
);

    logic [57:0] hist_q;
    logic [57:0] hist_d;

    always_comb begin
        hist_d   = hist_q;
        data_out = '0;
        // NOTE: blocking assignments are intentional here; each loop iteration
        // must see the history already shifted by the previous, more significant bit.
        for (int i = PAYLOAD_W - 1; i >= 0; i--) begin
            data_out[i] = data_in[i] ^ hist_d[38] ^ hist_d[57];
            hist_d      = {hist_d[56:0], data_in[i]};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hist_q <= '0;
        end else if (clr) begin
            hist_q <= '0;
        end else if (en) begin
            hist_q <= hist_d;
        end
    end

endmodule

// File: rtl/frame_aligner.sv
// -----------------------------------------------------------------------------
// frame_aligner
// Latches the header seeker's offset when the seeker reports sync. While
// locked, it extracts one 66-bit block (2-bit header plus 64-bit payload) from
// the gearbox buffer on every valid buffer cycle. A windowed bad-header monitor
// drops lock and pulses resync_o once BAD_MAX invalid headers fall inside one
// WIN_LEN-block window.
// Optional macro FRAME_ALIGNER_DESCRAMBLE_EN: adds a 1+x^39+x^58 payload
// descrambler and one extra output stage. With it, blk_*, resync_o and the
// falling edge of locked arrive 2 cycles after buffer_dv instead of 1.
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   gbox_buffer     complete 194-bit gearbox buffer
//   gbox_cnt        gearbox view window index
//   buffer_dv       buffer contents valid this cycle
//   is_synced       seeker sync flag
//   offset_pos      seeker header offset
//   blk_hdr         header of the extracted block
//   blk_data        payload of the extracted block
//   blk_valid       one-cycle strobe, block valid
//   blk_is_cmd      blk_hdr == 2'b10
//   blk_hdr_err     blk_hdr is neither 01 nor 10
//   locked          aligner is locked
//   lock_pos        offset latched at lock
//   resync_o        one-cycle pulse on loss of lock
//   hdr_err_cnt     saturating count of invalid headers seen while locked
// -----------------------------------------------------------------------------
module frame_aligner
    import rd53_link_pkg::*;
#(
    parameter int unsigned WIN_LEN = 64,
    parameter int unsigned BAD_MAX = 8,
    parameter int unsigned MAX_POS = 65
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [BUF_W-1:0]     gbox_buffer,
    input  logic [5:0]           gbox_cnt,
    input  logic                 buffer_dv,
    input  logic                 is_synced,
    input  logic [6:0]           offset_pos,
    output logic [1:0]           blk_hdr,
    output logic [PAYLOAD_W-1:0] blk_data,
    output logic                 blk_valid,
    output logic                 blk_is_cmd,
    output logic                 blk_hdr_err,
    output logic                 locked,
    output logic [6:0]           lock_pos,
    output logic                 resync_o,
    output logic [15:0]          hdr_err_cnt
);

    localparam int WIN_W = $clog2(WIN_LEN);
    localparam int BAD_W = $clog2(BAD_MAX + 1);

    align_state_t     state_q, state_d;
    logic             locked_fsm;
    logic [6:0]       lock_pos_q;
    logic [WIN_W-1:0] win_cnt_q;
    logic [BAD_W-1:0] bad_cnt_q;
    logic [BAD_W-1:0] bad_inc;
    logic [15:0]      hdr_err_cnt_q;

    // ---- Extraction -------------------------------------------------------
    // The header sits at H = 127 - gbox_cnt + lock_pos. The payload occupies
    // the 64 bits below it, so the block starts at bit H-64. One right shift
    // brings the whole 66-bit block down to bit 0.
    logic [7:0] hdr_pos;
    logic [7:0] blk_lsb;
    blk_t       blk_raw;

    assign hdr_pos = 8'd127 - {2'b00, gbox_cnt} + {1'b0, lock_pos_q};
    assign blk_lsb = hdr_pos - 8'd64;
    assign blk_raw = blk_t'(BLK_W'(gbox_buffer >> blk_lsb));

    // ---- Control ------------------------------------------------------------
    logic blk_en, blk_bad, lock_now, lose_lock;

    assign blk_en    = buffer_dv && (state_q == LOCKED);
    assign blk_bad   = !hdr_is_valid(blk_raw.hdr);
    assign bad_inc   = bad_cnt_q + BAD_W'(blk_bad);
    assign lose_lock = blk_en && blk_bad && (bad_inc == BAD_W'(BAD_MAX));
    assign lock_now  = (state_q == HUNT) && buffer_dv && is_synced
                       && (offset_pos <= 7'(MAX_POS));

    // ---- FSM ----------------------------------------------------------------
    // NOTE: state and every other register update with non-blocking
    // assignments, so all flops sample pre-edge values and never race each other.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= HUNT;
        else         state_q <= state_d;
    end

    // NOTE: state_d gets a default before the case, so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            HUNT:    if (lock_now)  state_d = LOCKED;
            LOCKED:  if (lose_lock) state_d = HUNT;
            default: state_d = HUNT;
        endcase
    end

    always_comb begin
        locked_fsm = (state_q == LOCKED);
    end

    // ---- Lock position and bad-header monitor ----------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lock_pos_q    <= '0;
            win_cnt_q     <= '0;
            bad_cnt_q     <= '0;
            hdr_err_cnt_q <= '0;
        end else if (lock_now) begin
            lock_pos_q <= offset_pos;
            win_cnt_q  <= '0;
            bad_cnt_q  <= '0;
        end else if (blk_en) begin
            // WIN_LEN is a power of two, so win_cnt_q wraps without extra logic.
            win_cnt_q <= win_cnt_q + 1'b1;
            // The last block of a window is already counted in bad_inc, and
            // lose_lock has compared it before this clear takes effect.
            if (win_cnt_q == WIN_W'(WIN_LEN - 1)) bad_cnt_q <= '0;
            else                                  bad_cnt_q <= bad_inc;
            if (blk_bad && (hdr_err_cnt_q != 16'hFFFF))
                hdr_err_cnt_q <= hdr_err_cnt_q + 16'd1;
        end
    end

    // ---- Output stage 1 ------------------------------------------------------
    blk_t blk_q;
    logic valid_q, cmd_q, err_q, resync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            blk_q    <= '0;
            valid_q  <= 1'b0;
            cmd_q    <= 1'b0;
            err_q    <= 1'b0;
            resync_q <= 1'b0;
        end else begin
            valid_q  <= blk_en;
            resync_q <= lose_lock;
            if (blk_en) begin
                blk_q <= blk_raw;
                cmd_q <= (blk_raw.hdr == C_CMD_HEADER);
                err_q <= blk_bad;
            end
        end
    end

    assign lock_pos    = lock_pos_q;
    assign hdr_err_cnt = hdr_err_cnt_q;

`ifdef FRAME_ALIGNER_DESCRAMBLE_EN
    // ---- Descrambler and output stage 2 -------------------------------------
    logic [PAYLOAD_W-1:0] plain;
    blk_t                 blk_q2;
    logic                 valid_q2, cmd_q2, err_q2, resync_q2;

    descrambler_58 u_descrambler (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .clr      (lock_now),
        .en       (valid_q),
        .data_in  (blk_q.data),
        .data_out (plain)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            blk_q2    <= '0;
            valid_q2  <= 1'b0;
            cmd_q2    <= 1'b0;
            err_q2    <= 1'b0;
            resync_q2 <= 1'b0;
        end else begin
            valid_q2  <= valid_q;
            resync_q2 <= resync_q;
            if (valid_q) begin
                blk_q2 <= '{hdr: blk_q.hdr, data: plain};
                cmd_q2 <= cmd_q;
                err_q2 <= err_q;
            end
        end
    end

    assign blk_hdr     = blk_q2.hdr;
    assign blk_data    = blk_q2.data;
    assign blk_valid   = valid_q2;
    assign blk_is_cmd  = cmd_q2;
    assign blk_hdr_err = err_q2;
    assign resync_o    = resync_q2;
    // Keep locked high while the loss-of-lock block is still in stage 2, so
    // it falls together with resync_o.
    assign locked      = locked_fsm | resync_q;
`else
    assign blk_hdr     = blk_q.hdr;
    assign blk_data    = blk_q.data;
    assign blk_valid   = valid_q;
    assign blk_is_cmd  = cmd_q;
    assign blk_hdr_err = err_q;
    assign resync_o    = resync_q;
    assign locked      = locked_fsm;
`endif

endmodule

// File: doc/frame_aligner.md
Name: frame_aligner

Overview:
- Sits directly downstream of the header seeker, alongside the gearbox.
- Latches the seeker's offset when the seeker reports sync, then extracts one 66-bit block (2-bit header plus 64-bit payload) from the gearbox buffer on every valid buffer cycle.
- Tolerates sparse header errors using a windowed bad-header monitor, and drops lock (with a resync pulse) when the monitor threshold is reached.
- Feeds the command/data decoders.

Parameters:
- WIN_LEN, 64: number of locked blocks per bad-header monitoring window; power of 2, 16..1024.
- BAD_MAX, 8: invalid headers within one window that force loss of lock; 1..WIN_LEN.
- MAX_POS, 65: largest legal offset_pos; a larger value is never latched.

Ports:
- clk_i  in  1  system clock
- rst_ni  in  1  asynchronous active-low reset
- gbox_buffer  in  194  complete gearbox buffer
- gbox_cnt  in  6  gearbox view window index
- buffer_dv  in  1  buffer contents valid this cycle
- is_synced  in  1  seeker sync flag
- offset_pos  in  7  seeker header offset
- blk_hdr  out  2  header of the extracted block
- blk_data  out  64  payload of the extracted block
- blk_valid  out  1  one-cycle strobe, block valid
- blk_is_cmd  out  1  blk_hdr == 2'b10
- blk_hdr_err  out  1  blk_hdr is neither 01 nor 10 (qualified by blk_valid)
- locked  out  1  FSM is in LOCKED
- lock_pos  out  7  offset latched at lock
- resync_o  out  1  one-cycle pulse on loss of lock
- hdr_err_cnt  out  16  saturating count of invalid headers while locked

Behaviour:
- Reset (async assert, sync release): all outputs are 0. The FSM enters HUNT. Window and bad counters are 0.
- Extraction:
  - H = 127 - gbox_cnt + lock_pos, computed in 8-bit unsigned arithmetic.
  - Header = gbox_buffer[H+1:H]; payload = gbox_buffer[H-1 -: 64].
  - Every legal (gbox_cnt, lock_pos) pair is in range: H spans 64..192.
  - Valid headers: 2'b01 (data) and 2'b10 (cmd).
- FSM HUNT:
  - blk_valid stays 0.
  - On a buffer_dv cycle with is_synced=1 and offset_pos <= MAX_POS: latch lock_pos <= offset_pos, clear the window and bad counters, and go to LOCKED on the next cycle.
  - is_synced=1 with offset_pos > MAX_POS is ignored.
- FSM LOCKED:
  - Each buffer_dv cycle registers blk_hdr, blk_data, blk_is_cmd and blk_hdr_err, and pulses blk_valid the next cycle. Latency is 1 cycle from buffer_dv.
  - is_synced and offset_pos are ignored while LOCKED. lock_pos is frozen.
  - Each block increments win_cnt. An invalid header also increments bad_cnt and hdr_err_cnt; hdr_err_cnt saturates at 16'hFFFF.
  - Window end: when win_cnt wraps (WIN_LEN-1 -> 0), bad_cnt clears. A bad header on the final block of a window is counted and compared before the clear.
  - If the incremented bad_cnt reaches BAD_MAX:
    - That block is still emitted with blk_hdr_err=1.
    - resync_o pulses in the same cycle as that blk_valid.
    - The FSM returns to HUNT, and locked falls in that same cycle.
- buffer_dv=0: no state changes. blk_valid=0 and the block outputs hold their values.
- HUNT -> LOCKED -> HUNT cannot happen within a single buffer_dv cycle. Relock requires a fresh is_synced observed in HUNT.
- Reset mid-block: the output strobe is lost, counters clear, and hdr_err_cnt returns to 0.

Optional Feature:
- Macro: FRAME_ALIGNER_DESCRAMBLE_EN
- Defined:
  - blk_data passes through a self-synchronous descrambler with polynomial 1 + x^39 + x^58 over the payload bits, MSB first. Headers are never descrambled.
  - The descrambler state is 58 bits. It is cleared on reset and on entry to LOCKED, and advances only on locked blocks.
  - One extra pipeline register is added: latency becomes 2 cycles for all blk_* outputs, resync_o and locked's falling edge.
- Undefined: raw payload is output with latency 1, and there is no descrambler logic.

Decomposition:
- Shared package `rd53_link_pkg`:
  - C_DATA_HEADER = 2'b01 and C_CMD_HEADER = 2'b10.
  - Buffer width 194 and block width 66.
  - typedef `align_state_t` {HUNT, LOCKED}.
  - struct `blk_t` {hdr[1:0], data[63:0]}.
- Sub-module `descrambler_58` is instantiated only under the macro. It is combinational on 64 bits, plus its state register with enable and clear inputs.

Test Plan:
- Lock at pos 17: send a 01-header stream with gbox_cnt sweeping 0..63, raise is_synced with offset_pos=17 -> locked=1, lock_pos=17, blk_valid one cycle after each buffer_dv, blk_data matches payload, blk_is_cmd=0.
- Cmd header: inject header 10 on block 5 -> blk_is_cmd=1 on exactly that strobe, and no error is counted.
- Threshold (BAD_MAX=8, WIN_LEN=64): 7 bad headers in one window -> stays locked and hdr_err_cnt=7. An 8th bad header in the same window -> resync_o pulses, locked falls in the same cycle, and the FSM is in HUNT.
- Window wrap: 7 bad headers in blocks 57..63, then 7 more in the next window -> no resync. A bad header on block 63 is counted before the bad counter clears.
- Gating and illegal offset: is_synced=1 with offset_pos=70 in HUNT -> no lock. buffer_dv held low for 10 cycles while locked -> no strobes and counters unchanged.
- Async reset asserted mid-stream while locked -> all outputs 0 immediately, and after release the block requires a new is_synced to relock. Under FRAME_ALIGNER_DESCRAMBLE_EN, a known scrambled PRBS input gives the expected plaintext with latency 2.
